// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch-stage state encoding, reset vector
// default, instruction width and the target-alignment helper.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_2000;

  // RUN    : sequential fetch, redirects honoured
  // SQUASH : wrong-path instructions still in flight, Kill held high
  // PEND   : redirect accepted during a stall, waiting for the stall to drop
  // TRAP   : misaligned target seen; frozen until reset
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    PEND   = 2'd2,
    TRAP   = 2'd3
  } fetch_state_e;

  // Jump targets ignore bit 0; the result is the address actually fetched.
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
    return t & ~{{(XLEN-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Sequential next-PC adder: PC + 4, wrapping modulo 2^32.
module pc_incrementer
  import pipeline_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  // Carry out of bit 31 is discarded, so 32'hFFFF_FFFC wraps to 0.
  assign pc_plus4 = pc + 32'd4;

endmodule

// File: rtl/fetch_redirect.sv
// Fetch PC register and redirect/squash control. Takes the branch decision
// from EX, steers fetch to the target, holds Kill high while wrong-path
// instructions drain, defers redirects that land during a stall and traps
// on misaligned targets.
//
// Handshake: there is no valid/ready pair here. Diverge is a one-cycle
// request that is only meaningful while Kill is low; Stall is a level that
// freezes all forward progress (PC and squash counter) for that cycle.
module fetch_redirect
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Diverge,
  input  logic [31:0] TargetPC,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Kill,
  output logic        InstValid,
  output logic        MisalignedFault,
  output logic [1:0]  dbg_state
);

  // Counter is loaded with FLUSH_DEPTH-1 so that Kill spans exactly
  // FLUSH_DEPTH un-stalled cycles (the final one is the counter==0 cycle).
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_DEPTH - 1);

  fetch_state_e      state_q, state_n;
  logic [XLEN-1:0]   pc_q, pc_n;
  logic [XLEN-1:0]   pend_q, pend_n;
  logic [2:0]        cnt_q, cnt_n;
  logic              kill_q, kill_n;
  logic              iv_q, iv_n;
  logic              fault_q, fault_n;

  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   tgt;
  logic              tgt_misaligned;
  logic              qual_div;

  pc_incrementer u_inc (
    .pc       (pc_q),
    .pc_plus4 (pc_plus4)
  );

  assign tgt            = align_target(TargetPC);
  assign tgt_misaligned = tgt[1];
  // A Diverge seen while Kill is high belongs to a squashed instruction.
  assign qual_div       = Diverge & ~kill_q;

  // State and datapath registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      iv_q    <= 1'b1;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      pend_q  <= pend_n;
      cnt_q   <= cnt_n;
      kill_q  <= kill_n;
      iv_q    <= iv_n;
      fault_q <= fault_n;
    end
  end

  // Next-state and next-datapath selection for the redirect FSM.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    pend_n  = pend_q;
    cnt_n   = cnt_q;
    kill_n  = kill_q;
    iv_n    = iv_q;
    fault_n = fault_q;

    unique case (state_q)
      RUN: begin
        if (qual_div && tgt_misaligned) begin
          // Trap takes precedence over the stall: nothing further may issue.
          fault_n = 1'b1;
          iv_n    = 1'b0;
          kill_n  = 1'b1;
          state_n = TRAP;
        end else if (qual_div && Stall) begin
          // Capture now; TargetPC may change while the stall persists.
          pend_n  = tgt;
          state_n = PEND;
        end else if (qual_div) begin
          pc_n    = tgt;
          kill_n  = 1'b1;
          iv_n    = 1'b0;
          cnt_n   = CNT_INIT;
          state_n = SQUASH;
        end else if (!Stall) begin
          pc_n = pc_plus4;
        end
      end

      SQUASH: begin
        if (!Stall) begin
          pc_n = pc_plus4;
          if (cnt_q != 3'd0) begin
            cnt_n = cnt_q - 3'd1;
          end else begin
            kill_n  = 1'b0;
            iv_n    = 1'b1;
            state_n = RUN;
          end
        end
      end

      PEND: begin
        // The stalled branch re-asserts Diverge; those repeats are ignored.
        if (!Stall) begin
          pc_n    = pend_q;
          kill_n  = 1'b1;
          iv_n    = 1'b0;
          cnt_n   = CNT_INIT;
          state_n = SQUASH;
        end
      end

      TRAP: begin
        kill_n  = 1'b1;
        iv_n    = 1'b0;
        fault_n = 1'b1;
      end

      default: begin
        state_n = RUN;
      end
    endcase
  end

  assign PC              = pc_q;
  assign PCPlus4         = pc_plus4;
  assign Kill            = kill_q;
  assign InstValid       = iv_q;
  assign MisalignedFault = fault_q;
  assign dbg_state       = state_q;

endmodule

// File: doc/fetch_redirect.md
# fetch_redirect

Program-counter and fetch-redirect stage of the RISC-V pipeline, downstream of branch control. Holds the architectural fetch PC and drives the instruction-memory address. Consumes the Diverge decision and the ALU-computed target, redirects fetch, and squashes the wrong-path instructions already in flight. Also honours hazard-unit stalls and traps misaligned targets.

## Interface
- RESET_PC, 32'h0000_2000: PC value loaded on reset.
- FLUSH_DEPTH, 2: number of cycles Kill stays asserted after a redirect; legal range 1–7.
- clk in 1: sole clock, rising edge.
- rst in 1: synchronous, active-high reset.
- Stall in 1: hazard-unit stall; freezes the PC and the squash counter.
- Diverge in 1: branch taken or jump, from branch control, for the instruction in EX.
- TargetPC in 32: jump or branch target from the ALU; bit 0 is ignored (forced 0).
- PC out 32: registered fetch address to instruction memory.
- PCPlus4 out 32: PC + 4, combinational; forwarded to the link-register writeback path.
- Kill out 1: registered; flushes the IF/ID and ID/EX pipeline registers.
- InstValid out 1: registered; the instruction fetched at PC is on the correct path.
- MisalignedFault out 1: registered, sticky instruction-address-misaligned flag.

## Operation
- State machine with four states: RUN, SQUASH, PEND, TRAP. Reset state is RUN.
- Reset values: PC=RESET_PC, Kill=0, InstValid=1, MisalignedFault=0, squash counter=0, pending-target register=0.
- Effective target: Tgt = {TargetPC[31:1],1'b0}. The target is misaligned when Tgt[1]=1.
- Diverge is qualified by ~Kill. While Kill=1, Diverge comes from a squashed instruction and is ignored.
- RUN:
  - No Stall, no qualified Diverge: PC<=PC+4. Arithmetic is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - Stall: PC holds and there are no other changes.
  - Qualified Diverge, aligned Tgt, no Stall: PC<=Tgt, Kill<=1, counter<=FLUSH_DEPTH-1, InstValid<=0. Go to SQUASH.
  - Qualified Diverge, aligned Tgt, with Stall: latch Tgt into the pending register. PC holds. Go to PEND.
  - Qualified Diverge, misaligned Tgt, with or without Stall: MisalignedFault<=1, InstValid<=0, Kill<=1. PC holds. Go to TRAP.
- SQUASH:
  - No Stall: PC<=PC+4. If counter≠0, decrement it. If counter=0, set Kill<=0 and InstValid<=1, and go to RUN.
  - Stall: PC and counter freeze; Kill stays 1.
- PEND:
  - Further Diverge pulses are ignored, because the stalled branch re-asserts Diverge.
  - On the first cycle with Stall=0: PC<=pending target, Kill<=1, counter<=FLUSH_DEPTH-1. Go to SQUASH.
- TRAP: terminal. PC holds, Kill=1, InstValid=0, MisalignedFault=1, and all inputs are ignored until rst.
- rst has priority over every input in every state, including mid-squash and PEND; the next cycle matches the reset values.

## Timing
- Zero-latency fetch address: PC is a register output, and instruction memory samples PC on the same edge.
- Redirect latency: Diverge sampled at edge t gives PC=Tgt after edge t, so the target is fetched in cycle t+1.
- Kill is high for exactly FLUSH_DEPTH un-stalled cycles, starting the cycle after the redirect edge. Stalled cycles extend the window one-for-one.
- With FLUSH_DEPTH=1, Kill is a single-cycle pulse and SQUASH lasts one un-stalled cycle.
- A Diverge arriving in the first RUN cycle after SQUASH is honoured (back-to-back redirects).
- PCPlus4 is purely combinational from PC; no other output is combinational.

## Structure
- Shared package pipeline_pkg holds:
  - the state encoding (2-bit enum RUN/SQUASH/PEND/TRAP),
  - the RESET_PC default,
  - the instruction width constant (32).
- One natural sub-module, pc_incrementer: PC+4 adder with wrap. Everything else (FSM, counter, pending register) stays in fetch_redirect.
- Expected size is about 150–250 lines.

## Test plan
- Reset then free-run: rst for 2 cycles, then 4 idle cycles → PC = 2000, 2004, 2008, 200C; Kill=0; InstValid=1.
- Taken branch: at PC=2010 pulse Diverge, TargetPC=3001 → next PC=3000; Kill=1 for exactly 2 cycles; InstValid returns 1 in the third cycle; MisalignedFault=0.
- Stall during redirect: Diverge with Stall=1 for 3 cycles, TargetPC=4000, with TargetPC changing to 5000 during the stall → PC frozen; Kill=0; after Stall drops, PC=4000 and Kill is high for 2 cycles.
- Diverge during squash ignored: redirect to 6000, then pulse Diverge with TargetPC=7000 while Kill=1 → PC follows 6000, 6004, …; no second redirect.
- Misaligned target: Diverge with TargetPC=8002 → MisalignedFault=1 and PC holds for 10 cycles regardless of inputs; rst clears the fault and gives PC=2000.
- Wrap and mid-squash reset: force PC=FFFF_FFFC via redirect, then 1 un-stalled cycle → PC=0. Assert rst while Kill=1 → next cycle Kill=0 and PC=2000.
